// File: rtl/mem_access_unit.sv
// Load/store initiator for port B of the dual-port word memory: sequences the 2-cycle
// read latency and read-modify-write for sub-word stores. Option: MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so one request is in flight at a time.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
`ifdef MISALIGN_TRAP_EN
        , S_ERR = 3'd6
`endif
    } state_t;

    state_t state, next_state;

    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [1:0]        lat_lane;
    logic              accept;
    logic              go_err;
    logic [1:0]        lane_eff;
    logic              unused_addr_hi;

    assign req_ready      = (state == S_IDLE);
    assign accept         = req_valid && req_ready;
    assign dbg_state      = state;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Lane forced to the natural alignment of the access size.
    always_comb begin
        lane_eff = 2'b00;
        case (req_size)
            2'b00:   lane_eff = req_addr[1:0];
            2'b01:   lane_eff = {req_addr[1], 1'b0};
            default: lane_eff = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign go_err     = (next_state == S_ERR);
`else
    assign go_err     = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] sz,
                                                  input logic [1:0] lane,
                                                  input logic uns);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                                input logic [1:0] sz,
                                                input logic [1:0] lane,
                                                input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = w;
        case (sz)
            2'b00:   r[{lane, 3'b000} +: 8]       = d[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16]  = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned)                  next_state = S_ERR;
                    else if (req_we && req_size[1])  next_state = S_WR;
                    else                             next_state = S_RD0;
`else
                    if (req_we && req_size[1])       next_state = S_WR;
                    else                             next_state = S_RD0;
`endif
                end
            end
            S_RD0:  next_state = S_RD1;
            S_RD1:  next_state = S_RD2;
            S_RD2:  next_state = lat_we ? S_WR : S_DONE;
            S_WR:   next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
`ifdef MISALIGN_TRAP_EN
            S_ERR:  next_state = S_IDLE;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered off next_state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
        end else begin
            resp_valid <= (next_state == S_DONE) || go_err;
            resp_err   <= go_err;
            mem_we     <= (next_state == S_WR);
            resp_rdata <= '0;
            if (accept) begin
                lat_we       <= req_we;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_lane     <= lane_eff;
                if (!go_err) begin
                    mem_addr  <= req_addr[ADDR_W+1:2];
                    mem_wdata <= req_wdata;
                end
            end
            if (state == S_RD2) begin
                if (lat_we) mem_wdata  <= merge(mem_rdata, lat_size, lat_lane, mem_wdata);
                else        resp_rdata <= extract(mem_rdata, lat_size, lat_lane, lat_unsigned);
            end
        end
    end

endmodule
